// File: rtl/wb_write_queue_if.sv
// Writeback request, bank write port and read-bypass signals of the write queue.
interface wb_write_queue_if #(
  parameter int W     = 32,
  parameter int DEPTH = 4
);
  logic                     alu_valid;
  logic                     alu_ready;
  logic [4:0]               alu_reg;
  logic [W-1:0]             alu_data;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [4:0]               mem_reg;
  logic [W-1:0]             mem_data;
  logic                     RegWrite;
  logic [4:0]               write_reg_in;
  logic [W-1:0]             write_data_in;
  logic [4:0]               IROut1;
  logic [4:0]               IROut2;
  logic                     fwd1_hit;
  logic [W-1:0]             fwd1_data;
  logic                     fwd2_hit;
  logic [W-1:0]             fwd2_data;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, IROut1, IROut2,
    output alu_ready, mem_ready, RegWrite, write_reg_in, write_data_in,
           fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
  );

  modport slave (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, IROut1, IROut2,
    input  alu_ready, mem_ready, RegWrite, write_reg_in, write_data_in,
           fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
  );
endinterface

// File: rtl/wb_write_queue.sv
// In-order writeback FIFO feeding the register bank's single write port, with
// read-side bypass of pending values (youngest match wins).
module wb_write_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  wb_write_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] C_FULLM1 = CW'(DEPTH - 1);

  logic [4:0]    r_reg  [DEPTH];
  logic [W-1:0]  r_data [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;

  logic          w_mem_ready;
  logic          w_alu_ready;
  logic          w_mem_push;
  logic          w_alu_push;
  logic          w_pop;
  logic [AW-1:0] w_alu_slot;
  logic [W:0]    w_fwd1;
  logic [W:0]    w_fwd2;

  // Ready looks only at occupancy so a full queue refuses even while it drains.
  assign w_mem_ready = (r_cnt < C_FULL);
  assign w_alu_ready = bus.mem_valid ? (r_cnt < C_FULLM1) : (r_cnt < C_FULL);

  assign w_mem_push = bus.mem_valid && w_mem_ready && (bus.mem_reg != 5'd0);
  assign w_alu_push = bus.alu_valid && w_alu_ready && (bus.alu_reg != 5'd0);
  assign w_pop      = (r_cnt != '0);
  assign w_alu_slot = r_wr + AW'(w_mem_push);

  function automatic logic [W:0] fwd_lookup(input logic [4:0] addr);
    logic          hit;
    logic [W-1:0]  data;
    logic [AW-1:0] idx;
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_rd + AW'(i);
      if ((CW'(i) < r_cnt) && (addr != 5'd0) && (r_reg[idx] == addr)) begin
        hit  = 1'b1;
        data = r_data[idx];
      end
    end
    return {hit, data};
  endfunction

  always_comb begin
    w_fwd1 = fwd_lookup(bus.IROut1);
    w_fwd2 = fwd_lookup(bus.IROut2);
  end

  // Queue storage: mem entry is older than a same-cycle alu entry.
  always_ff @(posedge clk) begin
    if (w_mem_push) begin
      r_reg[r_wr]  <= bus.mem_reg;
      r_data[r_wr] <= bus.mem_data;
    end
    if (w_alu_push) begin
      r_reg[w_alu_slot]  <= bus.alu_reg;
      r_data[w_alu_slot] <= bus.alu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_mem_push) + AW'(w_alu_push);
      r_rd  <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
    end
  end

  assign bus.mem_ready     = w_mem_ready;
  assign bus.alu_ready     = w_alu_ready;
  assign bus.RegWrite      = w_pop;
  assign bus.write_reg_in  = w_pop ? r_reg[r_rd]  : 5'd0;
  assign bus.write_data_in = w_pop ? r_data[r_rd] : '0;
  assign bus.fwd1_hit      = w_fwd1[W];
  assign bus.fwd1_data     = w_fwd1[W-1:0];
  assign bus.fwd2_hit      = w_fwd2[W];
  assign bus.fwd2_data     = w_fwd2[W-1:0];
  assign bus.count         = r_cnt;
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: reset, drain latency, ordering, $zero, bypass, backpressure.
module tb_wb_write_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [36:0] wlog [$];
  logic [36:0] exp_q [$];

  wb_write_queue_if #(.W(32), .DEPTH(4)) bus ();

  wb_write_queue #(.W(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.RegWrite) wlog.push_back({bus.write_reg_in, bus.write_data_in});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic [4:0] mr, input logic [31:0] md,
                       input logic [4:0] ar, input logic [31:0] ad);
    bus.mem_valid = 1'b1; bus.mem_reg = mr; bus.mem_data = md;
    bus.alu_valid = 1'b1; bus.alu_reg = ar; bus.alu_data = ad;
  endtask

  task automatic idle;
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
  endtask

  initial begin
    int mcnt;
    int mn;
    int an;
    logic em;
    logic ea;
    bus.alu_valid = 0; bus.alu_reg = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_reg = 0; bus.mem_data = 0;
    bus.IROut1 = 0; bus.IROut2 = 0;

    #2;
    chk("rst_count", bus.count, 0);
    chk("rst_regwrite", bus.RegWrite, 0);
    chk("rst_fwd1_hit", bus.fwd1_hit, 0);
    chk("rst_fwd2_hit", bus.fwd2_hit, 0);
    chk("rst_wreg", bus.write_reg_in, 0);
    chk("rst_wdata", bus.write_data_in, 0);
    step; step;
    rst = 1'b0;
    step;
    wlog.delete();

    // single ALU write
    bus.alu_valid = 1; bus.alu_reg = 5; bus.alu_data = 32'h1234;
    #1;
    chk("alu_ready_empty", bus.alu_ready, 1);
    step;
    idle;
    chk("single_regwrite", bus.RegWrite, 1);
    chk("single_wreg", bus.write_reg_in, 5);
    chk("single_wdata", bus.write_data_in, 32'h1234);
    chk("single_count1", bus.count, 1);
    step;
    chk("single_count0", bus.count, 0);
    chk("single_idle", bus.RegWrite, 0);
    chk("single_nwrites", wlog.size(), 1);
    if (wlog.size() >= 1) chk("single_log", wlog[0], {5'd5, 32'h1234});

    // dual push ordering, same register
    wlog.delete();
    push2(5'd3, 32'hAAAA, 5'd3, 32'hBBBB);
    bus.IROut1 = 3;
    #1;
    chk("dual_alu_ready", bus.alu_ready, 1);
    chk("dual_nofwd_incoming", bus.fwd1_hit, 0);
    step;
    idle;
    chk("dual_count2", bus.count, 2);
    chk("dual_fwd_hit", bus.fwd1_hit, 1);
    chk("dual_fwd_young", bus.fwd1_data, 32'hBBBB);
    chk("dual_head_mem", bus.write_data_in, 32'hAAAA);
    step;
    chk("dual_head_alu", bus.write_data_in, 32'hBBBB);
    chk("dual_fwd_head", bus.fwd1_data, 32'hBBBB);
    chk("dual_count1", bus.count, 1);
    step;
    chk("dual_count0", bus.count, 0);
    chk("dual_fwd_gone", bus.fwd1_hit, 0);
    chk("dual_nwrites", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("dual_log0", wlog[0], {5'd3, 32'hAAAA});
      chk("dual_log1", wlog[1], {5'd3, 32'hBBBB});
    end

    // $zero drop
    bus.alu_valid = 1; bus.alu_reg = 0; bus.alu_data = 32'hFFFF;
    bus.IROut1 = 0;
    #1;
    chk("zero_ready", bus.alu_ready, 1);
    step;
    idle;
    chk("zero_count", bus.count, 0);
    chk("zero_regwrite", bus.RegWrite, 0);
    chk("zero_fwd", bus.fwd1_hit, 0);
    step;
    chk("zero_regwrite2", bus.RegWrite, 0);

    // forward youngest: leaves [7=1, 9=2, 7=3] after reg10 drains
    wlog.delete();
    push2(5'd10, 32'h10, 5'd7, 32'h1);
    step;
    push2(5'd9, 32'h2, 5'd7, 32'h3);
    step;
    idle;
    chk("fy_count3", bus.count, 3);
    bus.IROut1 = 7; bus.IROut2 = 9;
    #1;
    chk("fy_hit7", bus.fwd1_hit, 1);
    chk("fy_data7", bus.fwd1_data, 32'h3);
    chk("fy_hit9", bus.fwd2_hit, 1);
    chk("fy_data9", bus.fwd2_data, 32'h2);
    bus.IROut1 = 8;
    #1;
    chk("fy_miss8", bus.fwd1_hit, 0);
    bus.IROut1 = 7;
    step;
    chk("fy_after_pop", bus.fwd1_data, 32'h3);
    step; step;
    chk("fy_drained", bus.count, 0);
    chk("fy_nwrites", wlog.size(), 4);
    if (wlog.size() >= 4) begin
      chk("fy_log0", wlog[0], {5'd10, 32'h10});
      chk("fy_log1", wlog[1], {5'd7, 32'h1});
      chk("fy_log2", wlog[2], {5'd9, 32'h2});
      chk("fy_log3", wlog[3], {5'd7, 32'h3});
    end

    // reset mid-stream with 3 pending entries
    push2(5'd1, 32'h11, 5'd2, 32'h22);
    step;
    push2(5'd3, 32'h33, 5'd4, 32'h44);
    step;
    idle;
    chk("mrst_fill", bus.count, 3);
    wlog.delete();
    bus.IROut1 = 3;
    rst = 1'b1;
    #1;
    chk("mrst_count", bus.count, 0);
    chk("mrst_regwrite", bus.RegWrite, 0);
    chk("mrst_fwd", bus.fwd1_hit, 0);
    step;
    rst = 1'b0;
    step;
    chk("mrst_count_after", bus.count, 0);
    chk("mrst_no_write", wlog.size(), 0);

    // backpressure with both producers held valid
    wlog.delete();
    exp_q.delete();
    mcnt = 0; mn = 0; an = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      push2(5'(1 + mn), 32'h1000 + 32'(mn), 5'(16 + an), 32'h2000 + 32'(an));
      #1;
      em = (mcnt <= 3);
      ea = (mcnt <= 2);
      chk("bp_mem_ready", bus.mem_ready, em);
      chk("bp_alu_ready", bus.alu_ready, ea);
      chk("bp_count", bus.count, mcnt);
      chk("bp_count_max", (bus.count <= 4), 1);
      if (em) begin exp_q.push_back({bus.mem_reg, bus.mem_data}); mn++; end
      if (ea) begin exp_q.push_back({bus.alu_reg, bus.alu_data}); an++; end
      mcnt = mcnt + int'(em) + int'(ea) - int'(mcnt != 0);
      step;
    end
    idle;
    #1;
    chk("bp_count_end", bus.count, mcnt);
    chk("bp_alu_ready_nomem", bus.alu_ready, (mcnt <= 3));
    for (int k = 0; k < 5; k++) step;
    chk("bp_drained", bus.count, 0);
    chk("bp_nwrites", wlog.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < wlog.size()) chk($sformatf("bp_log%0d", k), wlog[k], exp_q[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
